// File: rtl/ide_pkg.sv
// Shared types and address-decode constants for the IDE PIO cycle engine.
package ide_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      ACTIVE,
      HOLD,
      RECOVER
   } ide_state_t;

   // Bit positions within the CPU address bus ADDR[23:12]
   localparam int REGION_HI = 15;
   localparam int REGION_LO = 14;
   localparam int CS1_BIT   = 12;
   localparam int CS2_BIT   = 13;
   localparam int CH_BIT    = 16;

   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Counters terminate on zero, so an N-cycle interval loads N-1.
   function automatic int ld_val(input int n);
      return (n > 0) ? n - 1 : 0;
   endfunction

endpackage

// File: rtl/ide_cycle_counter.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module ide_cycle_counter #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RESET_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/ide_pio_ctrl.sv
// ATA PIO cycle engine: parameterised setup/strobe/recovery timing, IORDY wait
// with timeout, and the boot-ROM overlay enable latch.
module ide_pio_ctrl
   import ide_pkg::*;
#(
   parameter int NUM_CH      = 1,
   parameter int SETUP_CYC   = 2,
   parameter int ACTIVE_CYC  = 4,
   parameter int RECOVER_CYC = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              CLK,
   input  logic              RESET_n,
   input  logic [23:12]      ADDR,
   input  logic              UDS_n,
   input  logic              LDS_n,
   input  logic              RW,
   input  logic              AS_n,
   input  logic              ide_access,
   input  logic              ide_enable,
   input  logic [NUM_CH-1:0] IORDY,
   output logic              DTACK,
   output logic              IOR_n,
   output logic              IOW_n,
   output logic [NUM_CH-1:0] IDECS1_n,
   output logic [NUM_CH-1:0] IDECS2_n,
   output logic              IDEBUF_OE,
   output logic              IDE_ROMEN,
   output logic              TIMEOUT_ERR
);

   localparam int CW = $clog2(max_of4(SETUP_CYC, ACTIVE_CYC, RECOVER_CYC, TIMEOUT_CYC) + 1);
   localparam logic [CW-1:0] SETUP_LD   = CW'(ld_val(SETUP_CYC));
   localparam logic [CW-1:0] ACTIVE_LD  = CW'(ld_val(ACTIVE_CYC));
   localparam logic [CW-1:0] RECOVER_LD = CW'(ld_val(RECOVER_CYC));
   localparam logic [CW-1:0] TIMEOUT_LD = CW'(ld_val(TIMEOUT_CYC));

   ide_state_t    state, state_nxt;
   logic          enabled;
   logic          ch_lat, cs1_lat, cs2_lat, rw_lat;
   logic          ch_sel, cs1_sel, cs2_sel;
   logic          start, ds, sel_rdy, in_cycle, set_err;
   logic          cnt_load, cnt_dec, cnt_zero;
   logic [CW-1:0] cnt_val;
   logic          to_load, to_dec, to_zero;
   logic          unused_addr;

   assign unused_addr = ^ADDR[23:17] ^ ADDR[14];

   ide_cycle_counter #(.W(CW)) u_phase_cnt (
      .CLK      (CLK),
      .RESET_n  (RESET_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   ide_cycle_counter #(.W(CW)) u_timeout_cnt (
      .CLK      (CLK),
      .RESET_n  (RESET_n),
      .load     (to_load),
      .load_val (TIMEOUT_LD),
      .dec      (to_dec),
      .zero     (to_zero)
   );

   assign IDE_ROMEN = !(ide_access && !enabled);
   assign ds        = !UDS_n || !LDS_n;

   // On the start edge the latches are not yet loaded, so decode ADDR directly.
   always_comb begin
      ch_sel  = ch_lat;
      cs1_sel = cs1_lat;
      cs2_sel = cs2_lat;
      if (start) begin
         ch_sel  = (NUM_CH > 1) ? ADDR[CH_BIT] : 1'b0;
         cs1_sel = (ADDR[REGION_HI:REGION_LO] == 2'b00) && !ADDR[CS1_BIT];
         cs2_sel = (ADDR[REGION_HI:REGION_LO] == 2'b00) && !ADDR[CS2_BIT];
      end
   end

   always_comb begin
      sel_rdy = IORDY[0];
      if (ch_lat) sel_rdy = IORDY[NUM_CH-1];
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      cnt_load  = 1'b0;
      cnt_val   = SETUP_LD;
      cnt_dec   = 1'b0;
      to_load   = 1'b0;
      to_dec    = 1'b0;
      set_err   = 1'b0;
      case (state)
         IDLE: begin
            if (ide_access && enabled && !AS_n) begin
               state_nxt = SETUP;
               start     = 1'b1;
               cnt_load  = 1'b1;
            end
         end
         SETUP: begin
            if (AS_n) begin
               state_nxt = (RECOVER_CYC == 0) ? IDLE : RECOVER;
               cnt_load  = 1'b1;
               cnt_val   = RECOVER_LD;
            end else if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else if (rw_lat || ds) begin
               state_nxt = ACTIVE;
               cnt_load  = 1'b1;
               cnt_val   = ACTIVE_LD;
               to_load   = 1'b1;
            end
         end
         ACTIVE: begin
            // IORDY is tested before the timeout so a same-edge rise wins.
            if (AS_n) begin
               state_nxt = (RECOVER_CYC == 0) ? IDLE : RECOVER;
               cnt_load  = 1'b1;
               cnt_val   = RECOVER_LD;
            end else if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else if (sel_rdy) begin
               state_nxt = HOLD;
            end else if (to_zero) begin
               state_nxt = HOLD;
               set_err   = 1'b1;
            end else begin
               to_dec = 1'b1;
            end
         end
         HOLD: begin
            if (AS_n) begin
               state_nxt = (RECOVER_CYC == 0) ? IDLE : RECOVER;
               cnt_load  = 1'b1;
               cnt_val   = RECOVER_LD;
            end
         end
         RECOVER: begin
            if (cnt_zero) state_nxt = IDLE;
            else          cnt_dec   = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign in_cycle = (state_nxt == SETUP) || (state_nxt == ACTIVE) || (state_nxt == HOLD);

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state       <= IDLE;
         enabled     <= 1'b0;
         ch_lat      <= 1'b0;
         cs1_lat     <= 1'b0;
         cs2_lat     <= 1'b0;
         rw_lat      <= 1'b0;
         IOR_n       <= 1'b1;
         IOW_n       <= 1'b1;
         IDECS1_n    <= '1;
         IDECS2_n    <= '1;
         DTACK       <= 1'b0;
         IDEBUF_OE   <= 1'b1;
         TIMEOUT_ERR <= 1'b0;
      end else begin
         state <= state_nxt;
         if (ide_access && ide_enable && !RW) enabled <= 1'b1;
         if (start) begin
            ch_lat  <= ch_sel;
            cs1_lat <= cs1_sel;
            cs2_lat <= cs2_sel;
            rw_lat  <= RW;
         end
         IOR_n     <= !((state_nxt == ACTIVE) && rw_lat);
         IOW_n     <= !((state_nxt == ACTIVE) && !rw_lat);
         DTACK     <= (state == HOLD) && (state_nxt == HOLD);
         IDEBUF_OE <= !(ide_access && enabled && !AS_n && in_cycle);
         for (int i = 0; i < NUM_CH; i++) begin
            IDECS1_n[i] <= !(in_cycle && cs1_sel && (ch_sel == 1'(i)));
            IDECS2_n[i] <= !(in_cycle && cs2_sel && (ch_sel == 1'(i)));
         end
         if (set_err) TIMEOUT_ERR <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ide_pio_ctrl.sv
// Directed bench for ide_pio_ctrl (two channels, default timing).
module tb_ide_pio_ctrl;

   logic         CLK = 1'b0;
   logic         RESET_n;
   logic [23:12] ADDR;
   logic         UDS_n, LDS_n, RW, AS_n;
   logic         ide_access, ide_enable;
   logic [1:0]   IORDY;
   logic         DTACK, IOR_n, IOW_n;
   logic [1:0]   IDECS1_n, IDECS2_n;
   logic         IDEBUF_OE, IDE_ROMEN, TIMEOUT_ERR;

   int tests = 0;
   int fails = 0;

   int         dt, s_lo, s_first;
   logic [1:0] cs1, cs2;
   logic       oe;

   ide_pio_ctrl #(.NUM_CH(2)) dut (
      .CLK         (CLK),
      .RESET_n     (RESET_n),
      .ADDR        (ADDR),
      .UDS_n       (UDS_n),
      .LDS_n       (LDS_n),
      .RW          (RW),
      .AS_n        (AS_n),
      .ide_access  (ide_access),
      .ide_enable  (ide_enable),
      .IORDY       (IORDY),
      .DTACK       (DTACK),
      .IOR_n       (IOR_n),
      .IOW_n       (IOW_n),
      .IDECS1_n    (IDECS1_n),
      .IDECS2_n    (IDECS2_n),
      .IDEBUF_OE   (IDEBUF_OE),
      .IDE_ROMEN   (IDE_ROMEN),
      .TIMEOUT_ERR (TIMEOUT_ERR)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One bus cycle. Cycle k counts clock edges after AS_n falls; the events
   // rdy_rise / ds_at / abort_at are applied right after sampling cycle k.
   task automatic do_cycle(input logic rw, input logic [11:0] addr, input int max_cyc,
                           input logic [1:0] rdy0, input int rdy_rise, input int ds_at,
                           input int abort_at, output int o_dt, output int o_lo,
                           output int o_first, output logic [1:0] o_cs1,
                           output logic [1:0] o_cs2, output logic o_oe);
      o_dt = 0; o_lo = 0; o_first = 0; o_cs1 = 2'b11; o_cs2 = 2'b11; o_oe = 1'b1;
      IORDY = rdy0; ADDR = addr; RW = rw; ide_access = 1'b1; AS_n = 1'b0;
      UDS_n = 1'b1; LDS_n = (ds_at == 0) ? 1'b0 : 1'b1;
      for (int k = 1; k <= max_cyc; k++) begin
         step();
         if ((rw ? IOR_n : IOW_n) == 1'b0) begin
            o_lo++;
            if (o_first == 0) begin
               o_first = k;
               o_cs1   = IDECS1_n;
               o_cs2   = IDECS2_n;
               o_oe    = IDEBUF_OE;
            end
         end
         if (DTACK) begin
            o_dt = k;
            break;
         end
         if (k == rdy_rise) IORDY = 2'b11;
         if (k == ds_at) LDS_n = 1'b0;
         if (k == abort_at) AS_n = 1'b1;
      end
      AS_n = 1'b1; ide_access = 1'b0; UDS_n = 1'b1; LDS_n = 1'b1; IORDY = 2'b11;
      step();
      if (o_dt != 0) begin
         check("dtack_release", int'(DTACK), 0);
         check("cs1_release", int'(IDECS1_n), 3);
      end
   endtask

   initial begin
      RESET_n = 1'b0; ADDR = '0; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1; AS_n = 1'b1;
      ide_access = 1'b0; ide_enable = 1'b0; IORDY = 2'b11;
      idle(2);
      check("rst_ior", int'(IOR_n), 1);
      check("rst_iow", int'(IOW_n), 1);
      check("rst_cs1", int'(IDECS1_n), 3);
      check("rst_cs2", int'(IDECS2_n), 3);
      check("rst_dtack", int'(DTACK), 0);
      check("rst_bufoe", int'(IDEBUF_OE), 1);
      check("rst_toerr", int'(TIMEOUT_ERR), 0);
      check("rst_romen", int'(IDE_ROMEN), 1);
      RESET_n = 1'b1;
      idle(2);

      // Access before the enable latch is set: no cycle, overlay active.
      ide_access = 1'b1; AS_n = 1'b0; RW = 1'b1; ADDR = 12'h002;
      #1;
      check("romen_disabled", int'(IDE_ROMEN), 0);
      idle(3);
      check("noen_dtack", int'(DTACK), 0);
      check("noen_ior", int'(IOR_n), 1);
      check("noen_bufoe", int'(IDEBUF_OE), 1);
      RW = 1'b0; ide_enable = 1'b1;
      step();
      check("romen_enabled", int'(IDE_ROMEN), 1);
      AS_n = 1'b1; ide_access = 1'b0; RW = 1'b1; ide_enable = 1'b0;
      idle(3);
      check("noen_no_cycle", int'(IDECS1_n), 3);

      // Read ch0, IORDY[1] low must not matter.
      do_cycle(1'b1, 12'h002, 12, 2'b01, 0, 0, 0, dt, s_lo, s_first, cs1, cs2, oe);
      check("rd_dtack_cyc", dt, 8);
      check("rd_ior_first", s_first, 3);
      check("rd_ior_len", s_lo, 4);
      check("rd_cs1", int'(cs1), 2);
      check("rd_cs2", int'(cs2), 3);
      check("rd_bufoe", int'(oe), 0);

      // Back-to-back read: two RECOVER cycles delay the start.
      do_cycle(1'b1, 12'h002, 16, 2'b11, 0, 0, 0, dt, s_lo, s_first, cs1, cs2, oe);
      check("b2b_dtack_cyc", dt, 10);
      check("b2b_ior_first", s_first, 5);
      check("b2b_ior_len", s_lo, 4);
      idle(4);

      // Write with data strobe arriving late; CS2 only.
      do_cycle(1'b0, 12'h001, 20, 2'b11, 0, 6, 0, dt, s_lo, s_first, cs1, cs2, oe);
      check("wr_iow_first", s_first, 7);
      check("wr_iow_len", s_lo, 4);
      check("wr_dtack_cyc", dt, 12);
      check("wr_cs1", int'(cs1), 3);
      check("wr_cs2", int'(cs2), 2);
      idle(4);

      // IORDY low for 10 samples after ACTIVE expiry.
      do_cycle(1'b1, 12'h002, 30, 2'b00, 16, 0, 0, dt, s_lo, s_first, cs1, cs2, oe);
      check("wait_dtack_cyc", dt, 18);
      check("wait_ior_len", s_lo, 14);
      check("wait_toerr", int'(TIMEOUT_ERR), 0);
      idle(4);

      // IORDY rises on the very edge the timeout would fire.
      do_cycle(1'b1, 12'h002, 300, 2'b00, 260, 0, 0, dt, s_lo, s_first, cs1, cs2, oe);
      check("edge_dtack_cyc", dt, 262);
      check("edge_toerr", int'(TIMEOUT_ERR), 0);
      idle(4);

      // IORDY never rises: timeout.
      do_cycle(1'b1, 12'h002, 300, 2'b00, 0, 0, 0, dt, s_lo, s_first, cs1, cs2, oe);
      check("to_dtack_cyc", dt, 262);
      check("to_toerr", int'(TIMEOUT_ERR), 1);
      idle(4);

      // Channel 1 selected by ADDR[16]; its IORDY gates the cycle.
      do_cycle(1'b1, 12'h012, 20, 2'b01, 12, 0, 0, dt, s_lo, s_first, cs1, cs2, oe);
      check("ch1_dtack_cyc", dt, 14);
      check("ch1_cs1", int'(cs1), 1);
      check("ch1_cs2", int'(cs2), 3);
      idle(4);

      // Abort mid-ACTIVE.
      do_cycle(1'b1, 12'h002, 12, 2'b11, 0, 0, 4, dt, s_lo, s_first, cs1, cs2, oe);
      check("abort_dtack", dt, 0);
      check("abort_ior_len", s_lo, 2);
      check("abort_ior_after", int'(IOR_n), 1);
      idle(4);

      // Reset pulsed while the strobe is low.
      ide_access = 1'b1; AS_n = 1'b0; RW = 1'b1; ADDR = 12'h002; IORDY = 2'b11;
      idle(4);
      check("pre_rst_ior", int'(IOR_n), 0);
      #1 RESET_n = 1'b0;
      #1;
      check("arst_ior", int'(IOR_n), 1);
      check("arst_cs1", int'(IDECS1_n), 3);
      check("arst_dtack", int'(DTACK), 0);
      check("arst_bufoe", int'(IDEBUF_OE), 1);
      check("arst_toerr", int'(TIMEOUT_ERR), 0);
      check("arst_romen", int'(IDE_ROMEN), 0);
      AS_n = 1'b1; ide_access = 1'b0;
      idle(2);
      RESET_n = 1'b1;
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
